scr_base_l3_bank_vb: RTL and testbench

SCR_BASE_L3_BANK_VB -- requirements
Module: scr_base_l3_bank_vb

---
 rtl/scr_base_l3_bank_vb.sv | 210 +++++++++++++++++++++
 tb/tb_scr_base_l3_bank_vb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr_base_l3_bank_vb.sv
// Victim buffer for one L3 bank.
// Dirty victims are inserted from the bank pipeline and written back to
// memory in round-robin order. A completed writeback returns the victim's
// data-buffer slot. An address lookup lets incoming requests detect
// conflicts with victims that are still resident.
module scr_base_l3_bank_vb #(
    parameter int VB_DEPTH        = 16,
    parameter int VB_PTR_SIZE     = $clog2(VB_DEPTH),
    parameter int LINE_ADDR_WIDTH = 28,
    parameter int DBUFF_PTR_SIZE  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    // dirty-victim insert
    input  logic                       alloc_vld,
    output logic                       alloc_rdy,
    input  logic [LINE_ADDR_WIDTH-1:0] alloc_addr,
    input  logic [DBUFF_PTR_SIZE-1:0]  alloc_dbuff_idx,
    // writeback request
    output logic                       wb_req_vld,
    input  logic                       wb_req_rdy,
    output logic [LINE_ADDR_WIDTH-1:0] wb_req_addr,
    output logic [DBUFF_PTR_SIZE-1:0]  wb_req_dbuff_idx,
    output logic [VB_PTR_SIZE-1:0]     wb_req_tag,
    // writeback completion
    input  logic                       wb_ack_vld,
    input  logic [VB_PTR_SIZE-1:0]     wb_ack_tag,
    // data-buffer slot return
    output logic                       free_vld,
    output logic [DBUFF_PTR_SIZE-1:0]  free_dbuff_idx,
    // conflict lookup
    input  logic                       lkp_vld,
    input  logic [LINE_ADDR_WIDTH-1:0] lkp_addr,
    output logic                       lkp_hit,
    output logic [VB_PTR_SIZE-1:0]     lkp_idx,
    // status
    output logic [VB_PTR_SIZE:0]       occupancy,
    output logic                       empty,
    output logic                       full,
    output logic                       ack_err
);

    typedef enum logic [1:0] {
        ST_INVALID = 2'd0,
        ST_PEND    = 2'd1,
        ST_ISSUED  = 2'd2
    } ent_state_t;

    localparam logic [VB_PTR_SIZE:0] DEPTH_CNT = (VB_PTR_SIZE+1)'(VB_DEPTH);

    ent_state_t                 ent_state_r [VB_DEPTH];
    logic [LINE_ADDR_WIDTH-1:0] ent_addr_r  [VB_DEPTH];
    logic [DBUFF_PTR_SIZE-1:0]  ent_dbuff_r [VB_DEPTH];

    logic [VB_PTR_SIZE-1:0]     rr_ptr_r;
    logic                       lock_vld_r;
    logic [VB_PTR_SIZE-1:0]     lock_idx_r;
    logic [VB_PTR_SIZE:0]       occ_r;
    logic                       ack_err_r;
    logic                       free_vld_r;
    logic [DBUFF_PTR_SIZE-1:0]  free_idx_r;

    logic                       alloc_found_s;
    logic [VB_PTR_SIZE-1:0]     alloc_idx_s;
    logic                       alloc_fire_s;
    logic                       rr_found_s;
    logic [VB_PTR_SIZE-1:0]     rr_idx_s;
    logic [VB_PTR_SIZE-1:0]     cand_s;
    logic [VB_PTR_SIZE-1:0]     sel_idx_s;
    logic                       issue_fire_s;
    logic                       ack_ok_s;
    logic                       hit_s;
    logic [VB_PTR_SIZE-1:0]     hit_idx_s;
    logic [VB_PTR_SIZE:0]       occ_next_s;

    // Lowest-index free entry receives the next allocation.
    always_comb begin
        alloc_found_s = 1'b0;
        alloc_idx_s   = '0;
        for (int i = VB_DEPTH - 1; i >= 0; i--) begin
            if (ent_state_r[i] == ST_INVALID) begin
                alloc_found_s = 1'b1;
                alloc_idx_s   = VB_PTR_SIZE'(i);
            end else begin
                alloc_idx_s   = alloc_idx_s;
            end
        end
    end

    // First pending entry at or after the round-robin pointer, wrapping.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = rr_ptr_r;
        cand_s     = rr_ptr_r;
        for (int i = 0; i < VB_DEPTH; i++) begin
            cand_s = rr_ptr_r + VB_PTR_SIZE'(i);
            if (!rr_found_s && (ent_state_r[cand_s] == ST_PEND)) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s;
            end else begin
                rr_idx_s   = rr_idx_s;
            end
        end
    end

    // Lowest-index resident (pending or issued) entry matching the lookup address.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = VB_DEPTH - 1; i >= 0; i--) begin
            if ((ent_state_r[i] != ST_INVALID) && (ent_addr_r[i] == lkp_addr)) begin
                hit_s     = 1'b1;
                hit_idx_s = VB_PTR_SIZE'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // A request that was presented but not taken keeps its slot until accepted,
    // so a younger allocation cannot change the presented fields.
    assign sel_idx_s    = lock_vld_r ? lock_idx_r : rr_idx_s;
    assign wb_req_vld   = rr_found_s && !rst;
    assign issue_fire_s = wb_req_vld && wb_req_rdy;
    assign ack_ok_s     = wb_ack_vld && (ent_state_r[wb_ack_tag] == ST_ISSUED);
    assign alloc_rdy    = !full && !rst;
    assign alloc_fire_s = alloc_vld && alloc_rdy && alloc_found_s;
    assign occ_next_s   = occ_r + {{VB_PTR_SIZE{1'b0}}, alloc_fire_s}
                                - {{VB_PTR_SIZE{1'b0}}, ack_ok_s};

    assign wb_req_addr      = ent_addr_r[sel_idx_s];
    assign wb_req_dbuff_idx = ent_dbuff_r[sel_idx_s];
    assign wb_req_tag       = sel_idx_s;

    assign lkp_hit   = lkp_vld && hit_s && !rst;
    assign lkp_idx   = lkp_hit ? hit_idx_s : {VB_PTR_SIZE{1'b0}};

    assign occupancy      = occ_r;
    assign empty          = (occ_r == {(VB_PTR_SIZE+1){1'b0}});
    assign full           = (occ_r == DEPTH_CNT);
    assign ack_err        = ack_err_r;
    assign free_vld       = free_vld_r;
    assign free_dbuff_idx = free_idx_r;

    // Entry state, round-robin pointer, presentation lock and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VB_DEPTH; i++) begin
                ent_state_r[i] <= ST_INVALID;
            end
            rr_ptr_r   <= '0;
            lock_vld_r <= 1'b0;
            lock_idx_r <= '0;
            occ_r      <= '0;
            ack_err_r  <= 1'b0;
            free_vld_r <= 1'b0;
            free_idx_r <= '0;
        end else begin
            free_vld_r <= ack_ok_s;
            if (ack_ok_s) begin
                free_idx_r <= ent_dbuff_r[wb_ack_tag];
            end else begin
                free_idx_r <= free_idx_r;
            end

            if (wb_ack_vld && !ack_ok_s) begin
                ack_err_r <= 1'b1;
            end else begin
                ack_err_r <= ack_err_r;
            end

            if (issue_fire_s) begin
                ent_state_r[sel_idx_s] <= ST_ISSUED;
                rr_ptr_r   <= sel_idx_s + VB_PTR_SIZE'(1);
                lock_vld_r <= 1'b0;
            end else if (wb_req_vld) begin
                lock_vld_r <= 1'b1;
                lock_idx_r <= sel_idx_s;
            end else begin
                lock_vld_r <= 1'b0;
            end

            if (ack_ok_s) begin
                ent_state_r[wb_ack_tag] <= ST_INVALID;
            end else begin
                occ_r <= occ_next_s;
            end

            if (alloc_fire_s) begin
                ent_state_r[alloc_idx_s] <= ST_PEND;
            end else begin
                occ_r <= occ_next_s;
            end

            occ_r <= occ_next_s;
        end
    end

    // Address and data-buffer payload; only meaningful while the entry is resident.
    always_ff @(posedge clk) begin
        if (alloc_fire_s) begin
            ent_addr_r[alloc_idx_s]  <= alloc_addr;
            ent_dbuff_r[alloc_idx_s] <= alloc_dbuff_idx;
        end else begin
            ent_addr_r[alloc_idx_s]  <= ent_addr_r[alloc_idx_s];
            ent_dbuff_r[alloc_idx_s] <= ent_dbuff_r[alloc_idx_s];
        end
    end

endmodule

// File: tb/tb_scr_base_l3_bank_vb.sv
// Self-checking bench for scr_base_l3_bank_vb: directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a behavioural model of the victim buffer.
module tb_scr_base_l3_bank_vb;

    localparam int D  = 16;
    localparam int PW = 4;
    localparam int AW = 28;
    localparam int DW = 6;

    logic          clk;
    logic          rst;
    logic          alloc_vld, alloc_rdy;
    logic [AW-1:0] alloc_addr;
    logic [DW-1:0] alloc_dbuff_idx;
    logic          wb_req_vld, wb_req_rdy;
    logic [AW-1:0] wb_req_addr;
    logic [DW-1:0] wb_req_dbuff_idx;
    logic [PW-1:0] wb_req_tag;
    logic          wb_ack_vld;
    logic [PW-1:0] wb_ack_tag;
    logic          free_vld;
    logic [DW-1:0] free_dbuff_idx;
    logic          lkp_vld, lkp_hit;
    logic [AW-1:0] lkp_addr;
    logic [PW-1:0] lkp_idx;
    logic [PW:0]   occupancy;
    logic          empty, full, ack_err;

    scr_base_l3_bank_vb #(
        .VB_DEPTH(D), .VB_PTR_SIZE(PW), .LINE_ADDR_WIDTH(AW), .DBUFF_PTR_SIZE(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_addr(alloc_addr),
        .alloc_dbuff_idx(alloc_dbuff_idx),
        .wb_req_vld(wb_req_vld), .wb_req_rdy(wb_req_rdy), .wb_req_addr(wb_req_addr),
        .wb_req_dbuff_idx(wb_req_dbuff_idx), .wb_req_tag(wb_req_tag),
        .wb_ack_vld(wb_ack_vld), .wb_ack_tag(wb_ack_tag),
        .free_vld(free_vld), .free_dbuff_idx(free_dbuff_idx),
        .lkp_vld(lkp_vld), .lkp_addr(lkp_addr), .lkp_hit(lkp_hit), .lkp_idx(lkp_idx),
        .occupancy(occupancy), .empty(empty), .full(full), .ack_err(ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: 0 = invalid, 1 = waiting for writeback, 2 = written back, awaiting ack
    int            m_st   [D];
    logic [AW-1:0] m_addr [D];
    logic [DW-1:0] m_db   [D];
    int            m_rr, m_occ, m_held;
    bit            m_err, m_free;
    logic [DW-1:0] m_fidx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_sel();
        if (m_held >= 0) return m_held;
        for (int i = 0; i < D; i++) begin
            if (m_st[(m_rr + i) % D] == 1) return (m_rr + i) % D;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_st[i] = 0; m_addr[i] = '0; m_db[i] = '0;
        end
        m_rr = 0; m_occ = 0; m_held = -1; m_err = 0; m_free = 0; m_fidx = '0;
    endtask

    task automatic model_compare();
        int  sel;
        bit  e_vld, e_hit;
        int  e_li;
        sel   = m_sel();
        e_vld = !rst && (sel >= 0);
        chk("m_alloc_rdy", alloc_rdy, 32'(!rst && (m_occ != D)));
        chk("m_wb_req_vld", wb_req_vld, 32'(e_vld));
        if (e_vld) begin
            chk("m_wb_req_tag", wb_req_tag, 32'(sel));
            chk("m_wb_req_addr", wb_req_addr, 32'(m_addr[sel]));
            chk("m_wb_req_dbuff", wb_req_dbuff_idx, 32'(m_db[sel]));
        end
        chk("m_free_vld", free_vld, 32'(m_free));
        if (m_free) chk("m_free_idx", free_dbuff_idx, 32'(m_fidx));
        e_hit = 0; e_li = 0;
        if (lkp_vld && !rst) begin
            for (int i = 0; i < D; i++) begin
                if (!e_hit && m_st[i] != 0 && m_addr[i] == lkp_addr) begin
                    e_hit = 1; e_li = i;
                end
            end
        end
        chk("m_lkp_hit", lkp_hit, 32'(e_hit));
        if (e_hit) chk("m_lkp_idx", lkp_idx, 32'(e_li));
        chk("m_occupancy", occupancy, 32'(m_occ));
        chk("m_empty", empty, 32'(m_occ == 0));
        chk("m_full", full, 32'(m_occ == D));
        chk("m_ack_err", ack_err, 32'(m_err));
    endtask

    task automatic model_update();
        int sel, ai;
        bit wfire, aok, afire;
        if (rst) begin
            model_reset();
            return;
        end
        sel   = m_sel();
        wfire = (sel >= 0) && wb_req_rdy;
        aok   = wb_ack_vld && (m_st[wb_ack_tag] == 2);
        afire = alloc_vld && (m_occ < D);
        ai = -1;
        for (int i = D - 1; i >= 0; i--) if (m_st[i] == 0) ai = i;
        if (afire) begin
            for (int i = 0; i < D; i++)
                assert (!(m_st[i] != 0 && m_addr[i] == alloc_addr))
                    else $error("bench allocated a resident address %0h", alloc_addr);
        end
        m_free = aok;
        if (aok) m_fidx = m_db[wb_ack_tag];
        if (wb_ack_vld && !aok) m_err = 1;
        if (wfire) begin
            m_st[sel] = 2;
            m_rr = (sel + 1) % D;
        end
        m_held = wfire ? -1 : sel;
        if (aok) m_st[wb_ack_tag] = 0;
        if (afire && ai >= 0) begin
            m_st[ai] = 1; m_addr[ai] = alloc_addr; m_db[ai] = alloc_dbuff_idx;
        end
        m_occ = m_occ + int'(afire) - int'(aok);
    endtask

    task automatic settle();
        #3;
        model_compare();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        settle();
        edge_step();
    endtask

    task automatic idle_in();
        alloc_vld = 1'b0; wb_ack_vld = 1'b0; lkp_vld = 1'b0;
    endtask

    typedef struct {
        bit rst, av; logic [AW-1:0] aa; logic [DW-1:0] ad;
        bit wr, kv; logic [PW-1:0] kt; bit lv; logic [AW-1:0] la;
        bit e_rdy, e_wv; logic [PW-1:0] e_tag; logic [DW-1:0] e_wdb;
        bit e_fv; logic [DW-1:0] e_fi; bit e_hit; logic [PW-1:0] e_li;
        logic [PW:0] e_occ; bit e_emp, e_err;
    } vec_t;

    vec_t vtab [12];
    logic [PW-1:0] h_tag;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_db;
    logic [AW-1:0] next_addr;

    initial begin
        //          rst   av    aa          ad    wr    kv    kt    lv    la          rdy   wv    tag   wdb   fv    fi    hit   li    occ   emp   err
        vtab[0]  = '{1'b1,1'b0,28'h0,      6'd0, 1'b0,1'b0,4'd0, 1'b0,28'h0,      1'b0,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b0};
        vtab[1]  = '{1'b0,1'b1,28'h100,    6'd5, 1'b0,1'b0,4'd0, 1'b1,28'h100,    1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b0};
        vtab[2]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b0,1'b0,4'd0, 1'b1,28'h100,    1'b1,1'b1,4'd0, 6'd5, 1'b0,6'd0, 1'b1,4'd0, 5'd1, 1'b0,1'b0};
        vtab[3]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b1,28'h100,    1'b1,1'b1,4'd0, 6'd5, 1'b0,6'd0, 1'b1,4'd0, 5'd1, 1'b0,1'b0};
        vtab[4]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b1,28'h100,    1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b1,4'd0, 5'd1, 1'b0,1'b0};
        vtab[5]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b1,4'd0, 1'b1,28'h100,    1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b1,4'd0, 5'd1, 1'b0,1'b0};
        vtab[6]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b1,28'h100,    1'b1,1'b0,4'd0, 6'd0, 1'b1,6'd5, 1'b0,4'd0, 5'd0, 1'b1,1'b0};
        vtab[7]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b1,4'd3, 1'b0,28'h0,      1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b0};
        vtab[8]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b0,28'h0,      1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b1};
        vtab[9]  = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b0,28'h0,      1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b1};
        vtab[10] = '{1'b1,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b0,28'h0,      1'b0,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b1};
        vtab[11] = '{1'b0,1'b0,28'h0,      6'd0, 1'b1,1'b0,4'd0, 1'b0,28'h0,      1'b1,1'b0,4'd0, 6'd0, 1'b0,6'd0, 1'b0,4'd0, 5'd0, 1'b1,1'b0};

        rst = 1'b1; idle_in(); wb_req_rdy = 1'b0;
        alloc_addr = '0; alloc_dbuff_idx = '0; wb_ack_tag = '0; lkp_addr = '0;
        model_reset();
        @(posedge clk); model_update(); #1;
        edge_step();

        // directed vector table: basic alloc/issue/ack, lookup, bad ack, reset
        for (int r = 0; r < 12; r++) begin
            rst = vtab[r].rst; alloc_vld = vtab[r].av; alloc_addr = vtab[r].aa;
            alloc_dbuff_idx = vtab[r].ad; wb_req_rdy = vtab[r].wr;
            wb_ack_vld = vtab[r].kv; wb_ack_tag = vtab[r].kt;
            lkp_vld = vtab[r].lv; lkp_addr = vtab[r].la;
            #3;
            chk($sformatf("t%0d_alloc_rdy", r), alloc_rdy, 32'(vtab[r].e_rdy));
            chk($sformatf("t%0d_wb_req_vld", r), wb_req_vld, 32'(vtab[r].e_wv));
            if (vtab[r].e_wv) begin
                chk($sformatf("t%0d_wb_req_tag", r), wb_req_tag, 32'(vtab[r].e_tag));
                chk($sformatf("t%0d_wb_req_dbuff", r), wb_req_dbuff_idx, 32'(vtab[r].e_wdb));
            end
            chk($sformatf("t%0d_free_vld", r), free_vld, 32'(vtab[r].e_fv));
            if (vtab[r].e_fv) chk($sformatf("t%0d_free_idx", r), free_dbuff_idx, 32'(vtab[r].e_fi));
            chk($sformatf("t%0d_lkp_hit", r), lkp_hit, 32'(vtab[r].e_hit));
            chk($sformatf("t%0d_lkp_idx", r), lkp_idx, 32'(vtab[r].e_li));
            chk($sformatf("t%0d_occupancy", r), occupancy, 32'(vtab[r].e_occ));
            chk($sformatf("t%0d_empty", r), empty, 32'(vtab[r].e_emp));
            chk($sformatf("t%0d_full", r), full, 32'(vtab[r].e_occ == 5'd16));
            chk($sformatf("t%0d_ack_err", r), ack_err, 32'(vtab[r].e_err));
            model_compare();
            edge_step();
        end

        // fill all entries with writeback stalled, then drain in tag order
        idle_in(); wb_req_rdy = 1'b0;
        for (int i = 0; i < D; i++) begin
            alloc_vld = 1'b1; alloc_addr = 28'h200 + 28'(i); alloc_dbuff_idx = 6'(i);
            cyc();
        end
        idle_in();
        settle();
        chk("fill_full", full, 32'd1);
        chk("fill_alloc_rdy", alloc_rdy, 32'd0);
        chk("fill_occupancy", occupancy, 32'd16);
        edge_step();
        wb_req_rdy = 1'b1;
        for (int i = 0; i < D; i++) begin
            settle();
            chk($sformatf("drain_tag%0d", i), wb_req_tag, 32'(i));
            chk($sformatf("drain_vld%0d", i), wb_req_vld, 32'd1);
            edge_step();
        end

        // full and all issued: ack tag 7 with alloc in the same cycle
        wb_req_rdy = 1'b0;
        wb_ack_vld = 1'b1; wb_ack_tag = 4'd7;
        alloc_vld = 1'b1; alloc_addr = 28'h300; alloc_dbuff_idx = 6'd9;
        settle();
        chk("ackfull_alloc_rdy", alloc_rdy, 32'd0);
        edge_step();
        wb_ack_vld = 1'b0;
        settle();
        chk("ackfull_retry_rdy", alloc_rdy, 32'd1);
        edge_step();
        alloc_vld = 1'b0; lkp_vld = 1'b1; lkp_addr = 28'h300;
        settle();
        chk("ackfull_lkp_hit", lkp_hit, 32'd1);
        chk("ackfull_lkp_idx", lkp_idx, 32'd7);
        chk("ackfull_occupancy", occupancy, 32'd16);
        edge_step();

        // stalled writeback request stays stable while allocations continue
        idle_in(); rst = 1'b1; cyc(); rst = 1'b0;
        alloc_vld = 1'b1; alloc_addr = 28'h400; alloc_dbuff_idx = 6'd1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            alloc_addr = 28'h401 + 28'(k); alloc_dbuff_idx = 6'(k + 2);
            settle();
            if (k == 0) begin
                h_tag = wb_req_tag; h_addr = 28'h400; h_db = 6'd1;
            end
            chk($sformatf("hold_tag%0d", k), wb_req_tag, 32'(h_tag));
            chk($sformatf("hold_addr%0d", k), wb_req_addr, 32'(h_addr));
            chk($sformatf("hold_dbuff%0d", k), wb_req_dbuff_idx, 32'(h_db));
            edge_step();
        end

        // randomized traffic against the model
        idle_in(); rst = 1'b1; cyc(); rst = 1'b0;
        next_addr = 28'h1000;
        for (int n = 0; n < 3000; n++) begin
            int s;
            rst = ($urandom_range(0, 249) == 0);
            alloc_vld = ($urandom_range(0, 1) == 1);
            alloc_addr = next_addr; next_addr = next_addr + 28'd1;
            alloc_dbuff_idx = 6'($urandom);
            wb_req_rdy = ($urandom_range(0, 3) != 0);
            wb_ack_vld = ($urandom_range(0, 2) == 0);
            wb_ack_tag = 4'($urandom);
            if ($urandom_range(0, 9) != 0) begin
                s = $urandom_range(0, D - 1);
                for (int i = 0; i < D; i++) begin
                    if (m_st[(s + i) % D] == 2) begin
                        wb_ack_tag = 4'((s + i) % D);
                        break;
                    end
                end
            end
            lkp_vld = ($urandom_range(0, 1) == 1);
            lkp_addr = ($urandom_range(0, 1) == 1) ? m_addr[$urandom_range(0, D - 1)]
                                                   : 28'($urandom_range(28'h1000, 28'h1000 + 28'd4000));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
